jtag_tap_responder: RTL and testbench

- JTAG target-side TAP: receives TCK/TMS/TDI from an external JTAG master and drives TDO back, so an FTDI bitbang JTAG host can talk to FPGA fabric logic.
- The pins are oversampled in the system clock domain; no logic is clocked by TCK.
- Implements the IEEE 1149.1 16-state TAP FSM, a 4-bit IR, and three data registers: IDCODE, BYPASS and an 8-bit USER register with fabric-side capture/update.

---
 rtl/jtag_tap_responder.sv | 250 +++++++++++++++++++++++++
 tb/tb_jtag_tap_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder
//   Target-side JTAG TAP driven from pins oversampled in the clk domain. No
//   logic is clocked by TCK. It provides the 16-state TAP controller, a 4-bit
//   instruction register, and the IDCODE, BYPASS and USER data registers.
//
// Ports
//   clk, rstn        system clock, asynchronous active-low reset
//   tck, tms, tdi    raw JTAG pins (asynchronous to clk)
//   tdo, tdo_oe      JTAG data out and its output enable (set while shifting)
//   tap_state        current TAP state code
//   user_in          parallel value loaded into USER in Capture-DR
//   user_out         USER value latched in Update-DR
//   user_update      one-clk pulse in the clk that user_out changes
//
// Build option
//   JTAG_TAP_TCK_FILTER_EN: adds a 3-sample stability filter on the synchronised
//   tck. This ignores one-clk glitches and makes the pin-to-output latency 6 clk
//   instead of 3.
//
// USER_LEN must be at least 2.

module jtag_tap_responder #(
    parameter logic [31:0] IDCODE   = 32'h1234_5001,
    parameter int          USER_LEN = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                tck,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_oe,
    output logic [3:0]          tap_state,
    input  logic [USER_LEN-1:0] user_in,
    output logic [USER_LEN-1:0] user_out,
    output logic                user_update
);

    typedef enum logic [3:0] {
        TLR      = 4'hF, RTI      = 4'hC,
        SEL_DR   = 4'h7, CAP_DR   = 4'h6, SH_DR    = 4'h2, EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3, EX2_DR   = 4'h0, UPD_DR   = 4'h5,
        SEL_IR   = 4'h4, CAP_IR   = 4'hE, SH_IR    = 4'hA, EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB, EX2_IR   = 4'h8, UPD_IR   = 4'hD
    } tap_state_e;

    localparam logic [3:0] OP_IDCODE = 4'h1;
    localparam logic [3:0] OP_USER   = 4'h2;

    logic [1:0]          tck_sync_q, tms_sync_q, tdi_sync_q;
    logic                tck_s, tms_s, tdi_s, tck_lvl_s;
    logic                tck_prev_q, rise_s, fall_s;
    tap_state_e          state_q, state_d;
    logic [3:0]          ir_sr_q, ir_q;
    logic [31:0]         id_sr_q;
    logic [USER_LEN-1:0] user_sr_q, user_out_q;
    logic                byp_q, user_update_q, tdo_q, tdo_oe_q;
    logic                sel_id_s, sel_user_s, dr_lsb_s;

    // Two-flop synchronisers for the three asynchronous pins
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tck_sync_q <= 2'b00;
            tms_sync_q <= 2'b00;
            tdi_sync_q <= 2'b00;
        end else begin
            tck_sync_q <= {tck_sync_q[0], tck};
            tms_sync_q <= {tms_sync_q[0], tms};
            tdi_sync_q <= {tdi_sync_q[0], tdi};
        end
    end

    assign tck_s = tck_sync_q[1];
    assign tms_s = tms_sync_q[1];
    assign tdi_s = tdi_sync_q[1];

`ifdef JTAG_TAP_TCK_FILTER_EN
    logic [1:0] tck_hist_q;
    logic       tck_filt_q;

    // Accept a new tck level only after three consecutive identical samples
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tck_hist_q <= 2'b00;
            tck_filt_q <= 1'b0;
        end else begin
            tck_hist_q <= {tck_hist_q[0], tck_s};
            if ((tck_s == tck_hist_q[0]) && (tck_hist_q[0] == tck_hist_q[1])) begin
                tck_filt_q <= tck_s;
            end else begin
                tck_filt_q <= tck_filt_q;
            end
        end
    end

    assign tck_lvl_s = tck_filt_q;
`else
    assign tck_lvl_s = tck_s;
`endif

    // Previous tck level, used for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tck_prev_q <= 1'b0;
        end else begin
            tck_prev_q <= tck_lvl_s;
        end
    end

    assign rise_s = tck_lvl_s & ~tck_prev_q;
    assign fall_s = ~tck_lvl_s & tck_prev_q;

    // TAP state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // TAP next state. The controller only moves on a detected TCK rise.
    always_comb begin
        state_d = state_q;
        if (rise_s) begin
            case (state_q)
                TLR:      state_d = tms_s ? TLR    : RTI;
                RTI:      state_d = tms_s ? SEL_DR : RTI;
                SEL_DR:   state_d = tms_s ? SEL_IR : CAP_DR;
                CAP_DR:   state_d = tms_s ? EX1_DR : SH_DR;
                SH_DR:    state_d = tms_s ? EX1_DR : SH_DR;
                EX1_DR:   state_d = tms_s ? UPD_DR : PAUSE_DR;
                PAUSE_DR: state_d = tms_s ? EX2_DR : PAUSE_DR;
                EX2_DR:   state_d = tms_s ? UPD_DR : SH_DR;
                UPD_DR:   state_d = tms_s ? SEL_DR : RTI;
                SEL_IR:   state_d = tms_s ? TLR    : CAP_IR;
                CAP_IR:   state_d = tms_s ? EX1_IR : SH_IR;
                SH_IR:    state_d = tms_s ? EX1_IR : SH_IR;
                EX1_IR:   state_d = tms_s ? UPD_IR : PAUSE_IR;
                PAUSE_IR: state_d = tms_s ? EX2_IR : PAUSE_IR;
                EX2_IR:   state_d = tms_s ? UPD_IR : SH_IR;
                UPD_IR:   state_d = tms_s ? SEL_DR : RTI;
                default:  state_d = TLR;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Any opcode other than IDCODE or USER selects BYPASS
    assign sel_id_s   = (ir_q == OP_IDCODE);
    assign sel_user_s = (ir_q == OP_USER);

    // LSB of the data register picked by the active instruction
    always_comb begin
        dr_lsb_s = byp_q;
        if (sel_id_s) begin
            dr_lsb_s = id_sr_q[0];
        end else if (sel_user_s) begin
            dr_lsb_s = user_sr_q[0];
        end else begin
            dr_lsb_s = byp_q;
        end
    end

    // Capture and shift of the IR and DR shift registers on a TCK rise
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ir_sr_q   <= 4'h0;
            id_sr_q   <= 32'h0000_0000;
            user_sr_q <= '0;
            byp_q     <= 1'b0;
        end else if (rise_s) begin
            case (state_q)
                CAP_IR: ir_sr_q <= 4'b0001;
                SH_IR:  ir_sr_q <= {tdi_s, ir_sr_q[3:1]};
                CAP_DR: begin
                    if (sel_id_s) begin
                        id_sr_q <= IDCODE;
                    end else if (sel_user_s) begin
                        user_sr_q <= user_in;
                    end else begin
                        byp_q <= 1'b0;
                    end
                end
                SH_DR: begin
                    if (sel_id_s) begin
                        id_sr_q <= {tdi_s, id_sr_q[31:1]};
                    end else if (sel_user_s) begin
                        user_sr_q <= {tdi_s, user_sr_q[USER_LEN-1:1]};
                    end else begin
                        byp_q <= tdi_s;
                    end
                end
                default: ;
            endcase
        end
    end

    // Active instruction. Test-Logic-Reset forces IDCODE on every clk.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ir_q <= OP_IDCODE;
        end else if (state_q == TLR) begin
            ir_q <= OP_IDCODE;
        end else if (rise_s && (state_q == UPD_IR)) begin
            ir_q <= ir_sr_q;
        end else begin
            ir_q <= ir_q;
        end
    end

    // USER parallel output and its one-clk update strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            user_out_q    <= '0;
            user_update_q <= 1'b0;
        end else if (rise_s && (state_q == UPD_DR) && sel_user_s) begin
            user_out_q    <= user_sr_q;
            user_update_q <= 1'b1;
        end else begin
            user_update_q <= 1'b0;
        end
    end

    // TDO launch on a TCK fall. tdo keeps its last value outside the shift states.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tdo_q    <= 1'b1;
            tdo_oe_q <= 1'b0;
        end else if (fall_s) begin
            if (state_q == SH_IR) begin
                tdo_q    <= ir_sr_q[0];
                tdo_oe_q <= 1'b1;
            end else if (state_q == SH_DR) begin
                tdo_q    <= dr_lsb_s;
                tdo_oe_q <= 1'b1;
            end else begin
                tdo_oe_q <= 1'b0;
            end
        end
    end

    assign tap_state   = state_q;
    assign tdo         = tdo_q;
    assign tdo_oe      = tdo_oe_q;
    assign user_out    = user_out_q;
    assign user_update = user_update_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Testbench for jtag_tap_responder: directed JTAG sequences checked cycle by
// cycle against a queue-based behavioural model, plus literal expectations.
module tb_jtag_tap_responder;

`ifdef JTAG_TAP_TCK_FILTER_EN
    localparam int         LAT         = 6;
    localparam logic [3:0] GLITCH_EXP  = 4'hC;
`else
    localparam int         LAT         = 3;
    localparam logic [3:0] GLITCH_EXP  = 4'h7;
`endif
    localparam int HALF  = 8;
    localparam int SETUP = 4;

    logic       clk, rstn, tck, tms, tdi;
    logic       tdo, tdo_oe, user_update;
    logic [3:0] tap_state;
    logic [7:0] user_in, user_out;

    int checks = 0;
    int errors = 0;
    int clk_cnt = 0;
    int last_edge = 0;
    int upd_cnt = 0;

    // behavioural model state
    logic [3:0]  m_state = 4'hF;
    logic [3:0]  m_ir = 4'h1;
    logic        m_tdo = 1'b1;
    logic        m_oe = 1'b0;
    logic        m_pulse = 1'b0;
    logic [7:0]  m_user_out = 8'h00;
    bit          irq[$];
    bit          drq[$];
    logic [31:0] idc = 32'h1234_5001;

    // TAP transition table indexed by state code, for TMS=0 and TMS=1
    logic [3:0] nxt0 [0:15] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                                4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    logic [3:0] nxt1 [0:15] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                                4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

    jtag_tap_responder dut (
        .clk         (clk),
        .rstn        (rstn),
        .tck         (tck),
        .tms         (tms),
        .tdi         (tdi),
        .tdo         (tdo),
        .tdo_oe      (tdo_oe),
        .tap_state   (tap_state),
        .user_in     (user_in),
        .user_out    (user_out),
        .user_update (user_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) clk_cnt <= clk_cnt + 1;
    always @(posedge clk) if (user_update === 1'b1) upd_cnt <= upd_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_q(input bit q[$]);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < q.size() && i < 32; i++) v[i] = q[i];
        return v;
    endfunction

    task automatic model_reset();
        m_state = 4'hF; m_ir = 4'h1; m_tdo = 1'b1; m_oe = 1'b0;
        m_pulse = 1'b0; m_user_out = 8'h00;
        irq.delete(); drq.delete();
    endtask

    task automatic model_rise(input logic tms_v, input logic tdi_v);
        logic [31:0] v;
        case (m_state)
            4'hE: begin irq.delete(); irq.push_back(1); irq.push_back(0); irq.push_back(0); irq.push_back(0); end
            4'hA: begin void'(irq.pop_front()); irq.push_back(tdi_v); end
            4'hD: begin v = pack_q(irq); m_ir = v[3:0]; end
            4'h6: begin
                drq.delete();
                if (m_ir == 4'h1) for (int i = 0; i < 32; i++) drq.push_back(idc[i]);
                else if (m_ir == 4'h2) for (int i = 0; i < 8; i++) drq.push_back(user_in[i]);
                else drq.push_back(0);
            end
            4'h2: begin void'(drq.pop_front()); drq.push_back(tdi_v); end
            4'h5: if (m_ir == 4'h2) begin v = pack_q(drq); m_user_out = v[7:0]; m_pulse = 1'b1; end
            default: ;
        endcase
        m_state = tms_v ? nxt1[m_state] : nxt0[m_state];
        if (m_state == 4'hF) m_ir = 4'h1;
    endtask

    task automatic model_fall();
        m_pulse = 1'b0;
        if (m_state == 4'hA) m_tdo = irq[0];
        else if (m_state == 4'h2) m_tdo = drq[0];
        m_oe = (m_state == 4'hA) || (m_state == 4'h2);
    endtask

    // Per-cycle comparison once the last pin edge has had time to propagate
    always @(negedge clk) begin
        if (rstn === 1'b1 && (clk_cnt - last_edge) >= LAT) begin
            chk("tap_state", {28'h0, tap_state}, {28'h0, m_state});
            chk("tdo", {31'h0, tdo}, {31'h0, m_tdo});
            chk("tdo_oe", {31'h0, tdo_oe}, {31'h0, m_oe});
            chk("user_out", {24'h0, user_out}, {24'h0, m_user_out});
            chk("user_update", {31'h0, user_update},
                {31'h0, (m_pulse && ((clk_cnt - last_edge) == LAT))});
        end
    end

    // One TCK period; returns tdo/tdo_oe as seen just before this rise
    task automatic tck_cycle(input logic tms_v, input logic tdi_v,
                             output logic tdo_v, output logic oe_v);
        @(negedge clk); #1;
        tdo_v = tdo; oe_v = tdo_oe;
        tms = tms_v; tdi = tdi_v;
        repeat (SETUP) @(negedge clk);
        #1; tck = 1'b1; last_edge = clk_cnt; model_rise(tms_v, tdi_v);
        repeat (HALF) @(negedge clk);
        #1; tck = 1'b0; last_edge = clk_cnt; model_fall();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic tms_seq(input int n, input logic [31:0] bits);
        logic d0, d1;
        for (int i = 0; i < n; i++) tck_cycle(bits[i], 1'b0, d0, d1);
    endtask

    // Shift n bits LSB first, leaving the shift state on the last bit
    task automatic shift_reg(input int n, input logic [31:0] din,
                             output logic [31:0] dout, output int oe_cnt);
        logic b, o;
        dout = 32'h0; oe_cnt = 0;
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i], b, o);
            dout[i] = b;
            oe_cnt += int'(o);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dout;
        int          oe_cnt, upd0;
        logic        d0, d1;

        rstn = 1'b0; tck = 1'b0; tms = 1'b1; tdi = 1'b0; user_in = 8'hA5;
        model_reset();
        repeat (4) @(negedge clk);
        chk("rst_state", {28'h0, tap_state}, 32'hF);
        chk("rst_tdo", {31'h0, tdo}, 32'h1);
        chk("rst_tdo_oe", {31'h0, tdo_oe}, 32'h0);
        chk("rst_user_out", {24'h0, user_out}, 32'h0);
        chk("rst_user_update", {31'h0, user_update}, 32'h0);
        #1; rstn = 1'b1;
        repeat (4) @(negedge clk);

        // IDCODE read after reset
        tms_seq(4, 32'b0010);
        chk("enter_shdr", {28'h0, tap_state}, 32'h2);
        shift_reg(32, 32'h0, dout, oe_cnt);
        chk("idcode", dout, 32'h1234_5001);
        chk("idcode_oe", oe_cnt, 32);
        tms_seq(2, 32'b01);
        chk("rti", {28'h0, tap_state}, 32'hC);

        // IR capture value, then BYPASS loaded by shifting in all ones
        tms_seq(4, 32'b0011);
        chk("enter_shir", {28'h0, tap_state}, 32'hA);
        shift_reg(4, 32'hF, dout, oe_cnt);
        chk("ir_capture", dout, 32'h1);
        tms_seq(2, 32'b01);
        tms_seq(3, 32'b001);
        shift_reg(8, 32'hB2, dout, oe_cnt);
        chk("bypass", dout, 32'h64);
        tms_seq(2, 32'b01);

        // TMS reset from Shift-IR restores IDCODE
        tms_seq(4, 32'b0011);
        tms_seq(5, 32'b11111);
        chk("tms_reset", {28'h0, tap_state}, 32'hF);
        tms_seq(4, 32'b0010);
        shift_reg(8, 32'h0, dout, oe_cnt);
        chk("idcode_after_tms_reset", dout, 32'h01);
        tms_seq(2, 32'b01);

        // USER round trip
        tms_seq(4, 32'b0011);
        shift_reg(4, 32'h2, dout, oe_cnt);
        tms_seq(2, 32'b01);
        upd0 = upd_cnt;
        tms_seq(3, 32'b001);
        shift_reg(8, 32'h3C, dout, oe_cnt);
        chk("user_capture", dout, 32'hA5);
        chk("user_out_before_upd", {24'h0, user_out}, 32'h0);
        tms_seq(2, 32'b01);
        chk("user_out", {24'h0, user_out}, 32'h3C);
        chk("user_update_pulses", upd_cnt - upd0, 1);

        // Reset in the middle of a DR shift
        tms_seq(3, 32'b001);
        for (int i = 0; i < 3; i++) tck_cycle(1'b0, 1'b1, d0, d1);
        @(negedge clk); #1;
        rstn = 1'b0; model_reset();
        repeat (3) @(negedge clk);
        chk("midshift_rst_state", {28'h0, tap_state}, 32'hF);
        chk("midshift_rst_tdo_oe", {31'h0, tdo_oe}, 32'h0);
        chk("midshift_rst_tdo", {31'h0, tdo}, 32'h1);
        chk("midshift_rst_user_out", {24'h0, user_out}, 32'h0);
        #1; rstn = 1'b1;
        repeat (4) @(negedge clk);

        // One-clk tck glitch in Run-Test/Idle with TMS high
        tms_seq(1, 32'b0);
        chk("glitch_pre", {28'h0, tap_state}, 32'hC);
        @(negedge clk); #1; tms = 1'b1; tdi = 1'b0;
        repeat (SETUP) @(negedge clk);
        #1; tck = 1'b1;
`ifndef JTAG_TAP_TCK_FILTER_EN
        last_edge = clk_cnt; model_rise(1'b1, 1'b0);
`endif
        @(negedge clk); #1; tck = 1'b0;
`ifndef JTAG_TAP_TCK_FILTER_EN
        last_edge = clk_cnt; model_fall();
`endif
        repeat (12) @(negedge clk);
        chk("glitch_state", {28'h0, tap_state}, {28'h0, GLITCH_EXP});
        tms_seq(5, 32'b11111);
        chk("final_tlr", {28'h0, tap_state}, 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
